// File: rtl/sbox_layer_scheduler.sv
// sbox_layer_scheduler
// Runs one SKINNY-64 S-box layer: the 16 masked nibbles go one at a time
// through a single shared masked 4-bit S-box core. For each nibble the block
// fetches fresh randomness, holds the core inputs steady for the core latency,
// captures the core output into an internal buffer and flags a missing Synch.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   start               begin a layer (honoured only in IDLE)
//   busy, done, err     status: not idle / one-cycle completion / sticky Synch error
//   state_in/state_out  masked state, nibble i share k at [16i+4k +: 4]
//   rnd_req/valid/data  fresh-randomness handshake (transfer = req & valid)
//   sbox_x/sbox_fresh   core inputs, zero outside the ISSUE/WAIT window
//   sbox_y/sbox_synch   core output and its Synch flag
module sbox_layer_scheduler #(
    parameter int SECURITY_ORDER = 3,
    parameter int NUM_NIBBLES    = 16,
    parameter int SBOX_LATENCY   = 4,
    parameter int FRESH_WIDTH    = 24
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        err,
    input  logic [NUM_NIBBLES*4*(SECURITY_ORDER+1)-1:0] state_in,
    output logic [NUM_NIBBLES*4*(SECURITY_ORDER+1)-1:0] state_out,
    output logic                                        rnd_req,
    input  logic                                        rnd_valid,
    input  logic [FRESH_WIDTH-1:0]                      rnd_data,
    output logic [4*(SECURITY_ORDER+1)-1:0]             sbox_x,
    output logic [FRESH_WIDTH-1:0]                      sbox_fresh,
    input  logic [4*(SECURITY_ORDER+1)-1:0]             sbox_y,
    input  logic                                        sbox_synch
);
    localparam int NW = 4 * (SECURITY_ORDER + 1);   // bits per masked nibble
    localparam int IW = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
    localparam int CW = (SBOX_LATENCY > 1) ? $clog2(SBOX_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_e;

    state_e                         state_q, state_d;
    logic [NUM_NIBBLES-1:0][NW-1:0] buf_q, buf_d;
    logic [NUM_NIBBLES-1:0][NW-1:0] out_q, out_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [NW-1:0]                  x_q, x_d;
    logic [FRESH_WIDTH-1:0]         fresh_q, fresh_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           err_q, err_d;
    logic                           req_q, req_d;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        out_d   = out_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        fresh_d = fresh_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    buf_d   = state_in;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // The fresh bits go straight into the core-input register, so
                // the core sees the nibble and its randomness from ISSUE on.
                if (rnd_valid) begin
                    fresh_d = rnd_data;
                    x_d     = buf_q[idx_q];
                    req_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CW'(SBOX_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    // Capture even without Synch; err records the violation.
                    buf_d[idx_q] = sbox_y;
                    if (!sbox_synch) err_d = 1'b1;
                    x_d     = '0;
                    fresh_d = '0;
                    if (idx_q == IW'(NUM_NIBBLES - 1)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d   = IW'(idx_q + 1'b1);
                        req_d   = 1'b1;
                        state_d = FETCH;
                    end
                end else begin
                    cnt_d = CW'(cnt_q - 1'b1);
                end
            end
            DONE: begin
                out_d   = buf_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                req_d   = 1'b0;
                x_d     = '0;
                fresh_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            out_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            fresh_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            fresh_q <= fresh_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign rnd_req    = req_q;
    assign sbox_x     = x_q;
    assign sbox_fresh = fresh_q;
    assign state_out  = out_q;

endmodule

// File: tb/tb_sbox_layer_scheduler.sv
// Testbench for sbox_layer_scheduler: random masked layers against a
// behavioural S-box model, with stall, missing-Synch, busy-start and reset cases.
module tb_sbox_layer_scheduler;
    logic         clk, rst, start, busy, done, err;
    logic [255:0] state_in, state_out;
    logic         rnd_req, rnd_valid;
    logic [23:0]  rnd_data, sbox_fresh;
    logic [15:0]  sbox_x, sbox_y;
    logic         sbox_synch;

    sbox_layer_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .state_in(state_in), .state_out(state_out),
        .rnd_req(rnd_req), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
        .sbox_x(sbox_x), .sbox_fresh(sbox_fresh),
        .sbox_y(sbox_y), .sbox_synch(sbox_synch)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] sb(input logic [3:0] v);
        logic [63:0] tbl;
        tbl = 64'hFE7D4E5B_8A3B2A10 ^ 64'h0;
        // table S = C,6,9,0,1,A,2,B,3,8,5,D,4,E,7,F ; entry v at [4v +: 4]
        tbl = {4'hF,4'h7,4'hE,4'h4,4'hD,4'h5,4'h8,4'h3,4'hB,4'h2,4'hA,4'h1,4'h0,4'h9,4'h6,4'hC};
        return tbl[4*v +: 4];
    endfunction

    function automatic logic [3:0] recomb(input logic [15:0] n);
        return n[3:0] ^ n[7:4] ^ n[11:8] ^ n[15:12];
    endfunction

    // Bench core: correct masked S-box, output masks taken from the fresh bits.
    function automatic logic [15:0] core_f(input logic [15:0] x, input logic [23:0] f);
        logic [3:0] y;
        y = sb(recomb(x));
        return {f[11:8], f[7:4], f[3:0], y ^ f[3:0] ^ f[7:4] ^ f[11:8]};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core latency model: four pipeline registers.
    logic [15:0] ypipe [0:3];
    always @(posedge clk) begin
        ypipe[0] <= core_f(sbox_x, sbox_fresh);
        ypipe[1] <= ypipe[0];
        ypipe[2] <= ypipe[1];
        ypipe[3] <= ypipe[2];
    end
    assign sbox_y = ypipe[3];

    // Monitor state
    logic [255:0] layer_in;
    logic [23:0]  fresh_used [0:15];
    logic [15:0]  exp_x;
    logic [23:0]  exp_f;
    int           mon_nib, win_left, hyg_bad, xfer_cnt, done_cnt;
    bit           drop_en, stall_en;
    int           stall_left;

    // mon_nib becomes 10 at nibble 9's transfer and stays there until nibble
    // 10's transfer, covering nibble 9's whole window including its capture.
    assign sbox_synch = !(drop_en && mon_nib == 10);

    initial begin
        mon_nib = 0; win_left = 0; hyg_bad = 0; xfer_cnt = 0; done_cnt = 0;
        exp_x = '0; exp_f = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                win_left = 0;
            end else begin
                if (win_left > 0) begin
                    if (sbox_x !== exp_x || sbox_fresh !== exp_f) hyg_bad++;
                    win_left--;
                end else if (sbox_x !== 16'h0 || sbox_fresh !== 24'h0) begin
                    hyg_bad++;
                end
                if (done) done_cnt++;
                if (rnd_req && rnd_valid) begin
                    if (mon_nib < 16) begin
                        exp_x = layer_in[16*mon_nib +: 16];
                        fresh_used[mon_nib] = rnd_data;
                    end
                    exp_f    = rnd_data;
                    win_left = 5;
                    mon_nib++;
                    xfer_cnt++;
                end
            end
        end
    end

    // Randomness source, with an optional 3-cycle stall before nibble 5.
    initial begin
        rnd_valid = 1'b1; rnd_data = '0; stall_en = 0; stall_left = 0;
        forever begin
            @(posedge clk); #1;
            rnd_data = 24'($urandom);
            if (stall_en && mon_nib == 5 && rnd_req && stall_left > 0) begin
                rnd_valid = 1'b0;
                stall_left--;
            end else begin
                rnd_valid = 1'b1;
            end
        end
    end

    function automatic logic [255:0] make_state(input bit by_index);
        logic [255:0] s;
        logic [3:0]   v, s1, s2, s3;
        for (int i = 0; i < 16; i++) begin
            v  = by_index ? 4'(i) : 4'($urandom);
            s1 = 4'($urandom); s2 = 4'($urandom); s3 = 4'($urandom);
            s[16*i +: 16] = {s3, s2, s1, v ^ s1 ^ s2 ^ s3};
        end
        return s;
    endfunction

    task automatic run_layer(input string nm, input logic [255:0] din, input int exp_cyc,
                             input bit drop, input bit stall, input bit pulse);
        int cyc, dc0;
        bit got;
        logic [255:0] exp_full, alt;
        logic [63:0]  exp_rec, got_rec;
        alt = make_state(0);
        @(posedge clk); #1;
        state_in = din; layer_in = din;
        mon_nib = 0; xfer_cnt = 0; hyg_bad = 0; dc0 = done_cnt;
        drop_en = drop; stall_en = stall; stall_left = 3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; got = 0;
        while (cyc < 400) begin
            if (pulse) begin
                start = (cyc == 10 || cyc == 96 || cyc == 97);
                if (cyc == 10) state_in = alt;
            end
            @(negedge clk);
            if (cyc == 1) begin
                chk({nm, "_err_clr"}, 256'(err), 256'(0));
                chk({nm, "_busy"}, 256'(busy), 256'(1));
            end
            if (done) begin got = 1; break; end
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, "_done_seen"}, 256'(got), 256'(1));
        chk({nm, "_done_cycle"}, 256'(cyc), 256'(exp_cyc));
        chk({nm, "_err_at_done"}, 256'(err), 256'(drop));
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, "_done_pulse"}, 256'(done), 256'(0));
        chk({nm, "_idle"}, 256'(busy), 256'(0));
        exp_full = '0; exp_rec = '0; got_rec = '0;
        for (int i = 0; i < 16; i++) begin
            exp_full[16*i +: 16] = core_f(din[16*i +: 16], fresh_used[i]);
            exp_rec[4*i +: 4]    = sb(recomb(din[16*i +: 16]));
            got_rec[4*i +: 4]    = recomb(state_out[16*i +: 16]);
        end
        chk({nm, "_recombined"}, 256'(got_rec), 256'(exp_rec));
        chk({nm, "_shares"}, state_out, exp_full);
        chk({nm, "_rnd_xfers"}, 256'(xfer_cnt), 256'(16));
        chk({nm, "_hygiene"}, 256'(hyg_bad), 256'(0));
        repeat (pulse ? 110 : 4) @(posedge clk);
        #1;
        chk({nm, "_one_done"}, 256'(done_cnt - dc0), 256'(1));
        chk({nm, "_still_idle"}, 256'(busy), 256'(0));
        chk({nm, "_out_held"}, state_out, exp_full);
        drop_en = 0; stall_en = 0;
    endtask

    initial begin
        logic [255:0] d;
        int dc0;
        rst = 1'b1; start = 1'b0; state_in = '0; layer_in = '0; drop_en = 0;
        #1 rst = 1'b0;
        #2;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_req", 256'(rnd_req), 256'(0));
        chk("rst_x", 256'(sbox_x), 256'(0));
        chk("rst_fresh", 256'(sbox_fresh), 256'(0));
        chk("rst_out", state_out, 256'(0));
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        run_layer("basic", make_state(1), 97, 0, 0, 0);
        run_layer("rand", make_state(0), 97, 0, 0, 0);
        run_layer("stall", make_state(1), 100, 0, 1, 0);
        run_layer("nosynch", make_state(0), 97, 1, 0, 0);
        run_layer("clear", make_state(0), 97, 0, 0, 0);
        run_layer("busystart", make_state(0), 97, 0, 0, 1);

        // Reset in the middle of a layer.
        @(posedge clk); #1;
        d = make_state(0);
        state_in = d; layer_in = d; mon_nib = 0; dc0 = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy", 256'(busy), 256'(0));
        chk("mid_rst_req", 256'(rnd_req), 256'(0));
        chk("mid_rst_x", 256'({sbox_x, sbox_fresh}), 256'(0));
        chk("mid_rst_out", state_out, 256'(0));
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_done", 256'(done_cnt - dc0), 256'(0));
        chk("mid_rst_idle", 256'(busy), 256'(0));
        run_layer("after_rst", make_state(0), 97, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
